// File: rtl/la_pkg.sv
// la_pkg: constants, state encodings and helpers shared by both ends of the logic-analyzer UART link
package la_pkg;
    localparam int UART_BYTES_PER_WORD = 4;
    localparam bit MSB_FIRST = 1'b1;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
    function automatic int ch_bits(input int ch_no);
        return $clog2(ch_no);
    endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 byte deserializer with input synchronizer and framing checks
module uart_rx_byte
    import la_pkg::*;
#(
    parameter int BAUD_PRESCALER = 200
) (
    input  logic       i_clk,
    input  logic       _rst,
    input  logic       rx_pin,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       stop_err,
    output logic       start_edge
);
    localparam int CW = $clog2(BAUD_PRESCALER);
    rx_state_t state, state_n;
    logic rx_meta, rx_s, rx_prev, tick;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    assign start_edge = state == RX_IDLE && rx_prev && !rx_s;
    assign tick = cnt == '0;
    assign rx_byte = shreg;
    always_ff @(posedge i_clk) begin
        if (_rst) begin
            state <= RX_IDLE;
            rx_meta <= 1'b1;
            rx_s <= 1'b1;
            rx_prev <= 1'b1;
            cnt <= '0;
            bit_idx <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            {rx_s, rx_meta} <= {rx_meta, rx_pin};
            rx_prev <= rx_s;
            cnt <= start_edge ? CW'(BAUD_PRESCALER / 2 - 1) :
                   (tick || state == RX_IDLE) ? CW'(BAUD_PRESCALER - 1) : cnt - CW'(1);
            bit_idx <= state != RX_DATA ? 3'd0 : tick ? bit_idx + 3'd1 : bit_idx;
            if (state == RX_DATA && tick) shreg <= {rx_s, shreg[7:1]};
        end
    end
    // A low stop bit parks in RX_BREAK so a held-low line cannot retrigger start detection
    always_comb begin
        state_n = state;
        byte_valid = 1'b0;
        frame_err = 1'b0;
        stop_err = 1'b0;
        case (state)
            RX_IDLE:  state_n = start_edge ? RX_START : RX_IDLE;
            RX_START: if (tick) begin
                state_n = rx_s ? RX_IDLE : RX_DATA;
                frame_err = rx_s;
            end
            RX_DATA:  state_n = (tick && bit_idx == 3'd7) ? RX_STOP : RX_DATA;
            RX_STOP:  if (tick) begin
                state_n = rx_s ? RX_IDLE : RX_BREAK;
                byte_valid = rx_s;
                frame_err = !rx_s;
                stop_err = !rx_s;
            end
            RX_BREAK: state_n = rx_s ? RX_IDLE : RX_BREAK;
            default:  state_n = RX_IDLE;
        endcase
    end
endmodule

// File: rtl/transfer_rx.sv
// transfer_rx: UART word receiver that steers 32-bit words into per-channel holding registers
module transfer_rx
    import la_pkg::*;
#(
    parameter int CH_NO          = 4,
    parameter int BAUD_PRESCALER = 200,
    parameter int TIMEOUT_BITS   = 20
) (
    input  logic                 i_clk,
    input  logic                 _rst,
    input  logic                 rx_pin,
    output logic [32*CH_NO-1:0]  data_out,
    output logic [CH_NO-1:0]     available,
    input  logic [CH_NO-1:0]     read,
    output logic [CH_NO-1:0]     overflow,
    output logic                 frame_err
);
    localparam int CH_BITS = ch_bits(CH_NO);
    localparam int GAP = TIMEOUT_BITS * BAUD_PRESCALER;
    localparam int GW = $clog2(GAP);
    localparam int BW = $clog2(UART_BYTES_PER_WORD);
    localparam logic [31:0] MASK = 32'hFFFF_FFFF >> CH_BITS;
    logic byte_valid, rx_ferr, stop_err, start_edge, gap_run, expiry, dec, id_ok;
    logic [7:0] rx_byte;
    logic [31:0] word;
    logic [BW-1:0] cnt;
    logic [GW-1:0] gap;
    logic [CH_BITS-1:0] id;
    uart_rx_byte #(.BAUD_PRESCALER(BAUD_PRESCALER)) u_rx (
        .i_clk(i_clk),
        ._rst(_rst),
        .rx_pin(rx_pin),
        .byte_valid(byte_valid),
        .rx_byte(rx_byte),
        .frame_err(rx_ferr),
        .stop_err(stop_err),
        .start_edge(start_edge)
    );
    assign id = word[31 -: CH_BITS];
    assign id_ok = int'(id) < CH_NO;
    assign expiry = gap_run && gap == GW'(GAP - 1);
    // The gap timer also restarts on a false start so a glitch cannot strand a partial word
    always_ff @(posedge i_clk) begin
        if (_rst) begin
            word <= '0;
            cnt <= '0;
            gap <= '0;
            gap_run <= 1'b0;
            dec <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (byte_valid) word <= MSB_FIRST ? {word[23:0], rx_byte} : {rx_byte, word[31:8]};
            cnt <= (stop_err || expiry) ? '0 : byte_valid ? cnt + BW'(1) : cnt;
            gap <= (byte_valid || rx_ferr) ? '0 : gap + GW'(1);
            gap_run <= (byte_valid || rx_ferr) ? 1'b1 : (start_edge || expiry) ? 1'b0 : gap_run;
            dec <= byte_valid && cnt == BW'(UART_BYTES_PER_WORD - 1);
            frame_err <= rx_ferr || (dec && !id_ok);
        end
    end
    for (genvar c = 0; c < CH_NO; c++) begin : g_ch
        logic hit, avail, ovf;
        logic [31:0] data;
        assign hit = dec && id_ok && id == CH_BITS'(c);
        assign data_out[32*c +: 32] = data;
        assign available[c] = avail;
        assign overflow[c] = ovf;
        always_ff @(posedge i_clk) begin
            if (_rst) begin
                data <= '0;
                avail <= 1'b0;
                ovf <= 1'b0;
            end else if (hit) begin
                data <= word & MASK;
                avail <= 1'b1;
                ovf <= ovf || (avail && !read[c]);
            end else if (read[c]) begin
                avail <= 1'b0;
            end
        end
    end
endmodule
